// File: rtl/cipher_pkg.sv
// Shared types for the cipher nibble packer: pair record, packer states, nibble width.
package cipher_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_HOLD = 1'b1
  } packer_state_t;

  typedef struct packed {
    logic                last;
    logic [NIBBLE_W-1:0] key;
    logic [NIBBLE_W-1:0] enc;
  } cipher_pair_t;

endpackage

// File: rtl/cipher_pair_fifo.sv
// Synchronous FIFO of cipher_pair_t records; full/empty come from a registered occupancy count.
module cipher_pair_fifo
  import cipher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  cipher_pair_t push_data_i,
  input  logic         pop_i,
  output cipher_pair_t pop_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  cipher_pair_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cipher_nibble_packer.sv
// Packs buffered {enc,key} nibble pairs LSB-first into wide words with valid/ready on both sides.
// Optional running XOR checksum of the encrypt nibbles when CIPHER_PACKER_CHECKSUM_EN is defined.
module cipher_nibble_packer
  import cipher_pkg::*;
#(
  parameter int NIBBLES_PER_WORD = 4,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [NIBBLE_W-1:0]                     in_encrypt_data,
  input  logic [NIBBLE_W-1:0]                     in_private_key,
  input  logic                                    in_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [NIBBLE_W*NIBBLES_PER_WORD-1:0]    out_word,
  output logic [NIBBLE_W*NIBBLES_PER_WORD-1:0]    out_key_word,
  output logic [$clog2(NIBBLES_PER_WORD+1)-1:0]   out_len,
  output logic [NIBBLE_W-1:0]                     out_checksum
);

  localparam int W  = NIBBLE_W * NIBBLES_PER_WORD;
  localparam int LW = $clog2(NIBBLES_PER_WORD + 1);

  packer_state_t  state_q, state_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   word_q, word_d;
  logic [W-1:0]   key_q, key_d;

  cipher_pair_t   push_pair, pop_pair;
  logic           fifo_full, fifo_empty;
  logic           pop;
  logic           hs;

  assign push_pair = {in_last, in_private_key, in_encrypt_data};
  assign in_ready  = !fifo_full;

  cipher_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid),
    .push_data_i (push_pair),
    .pop_i       (pop),
    .pop_data_o  (pop_pair),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid    = (state_q == PK_HOLD);
  assign hs           = out_valid && out_ready;
  assign out_word     = word_q;
  assign out_key_word = key_q;
  assign out_len      = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    key_d   = key_q;
    pop     = 1'b0;
    case (state_q)
      PK_FILL: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          for (int i = 0; i < NIBBLES_PER_WORD; i++) begin
            if (cnt_q == LW'(i)) begin
              word_d[i*NIBBLE_W +: NIBBLE_W] = pop_pair.enc;
              key_d[i*NIBBLE_W +: NIBBLE_W]  = pop_pair.key;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LW'(NIBBLES_PER_WORD - 1) || pop_pair.last) state_d = PK_HOLD;
        end
      end
      PK_HOLD: begin
        // Handshake cycle never pops; the next fill starts the following cycle.
        if (hs) begin
          word_d  = '0;
          key_d   = '0;
          cnt_d   = '0;
          state_d = PK_FILL;
        end
      end
      default: state_d = PK_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PK_FILL;
      cnt_q   <= '0;
      word_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      key_q   <= key_d;
    end
  end

`ifdef CIPHER_PACKER_CHECKSUM_EN
  logic [NIBBLE_W-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (pop)     chk_d = chk_q ^ pop_pair.enc;
    else if (hs) chk_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign out_checksum = chk_q;
`else
  assign out_checksum = '0;
`endif

endmodule

// File: tb/tb_cipher_nibble_packer.sv
// Self-checking bench for cipher_nibble_packer: vector table, corner sequences, randomized traffic vs a packing model.
module tb_cipher_nibble_packer;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_encrypt_data;
  logic [3:0]   in_private_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic [W-1:0] out_key_word;
  logic [2:0]   out_len;
  logic [3:0]   out_checksum;

  cipher_nibble_packer #(.NIBBLES_PER_WORD(N), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_encrypt_data (in_encrypt_data),
    .in_private_key  (in_private_key),
    .in_last         (in_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_word        (out_word),
    .out_key_word    (out_key_word),
    .out_len         (out_len),
    .out_checksum    (out_checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] key;
    int           len;
    logic [3:0]   chk;
  } exp_t;

  typedef struct {
    logic [W-1:0] enc;
    logic [W-1:0] key;
    int           n;
    bit           last;
    logic [W-1:0] ew;
    logic [W-1:0] ek;
    int           elen;
    logic [3:0]   echk;
  } vec_t;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cycle   = 0;
  int hs_cnt  = 0;
  int acc_cycle;
  bit prev_ov = 1'b0;
  int rise_q[$];
  exp_t exp_q[$];
  logic [3:0] cur_enc [N];
  logic [3:0] cur_key [N];
  int cur_n = 0;
  logic [W-1:0] cap_word, cap_key;
  logic [3:0]   cap_chk;
  int           cap_len;
  vec_t vecs [5];

  function automatic logic [3:0] exp_chk(input logic [3:0] x);
`ifdef CIPHER_PACKER_CHECKSUM_EN
    return x;
`else
    return 4'h0;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Reference: a word closes after N accepted pairs or on a pair marked last.
  task automatic model_push(input logic [3:0] e, input logic [3:0] k, input logic l);
    exp_t x;
    cur_enc[cur_n] = e;
    cur_key[cur_n] = k;
    cur_n++;
    if (cur_n == N || l) begin
      x.word = '0; x.key = '0; x.chk = 4'h0; x.len = cur_n;
      for (int i = 0; i < cur_n; i++) begin
        x.word = x.word | (W'(cur_enc[i]) << (4 * i));
        x.key  = x.key  | (W'(cur_key[i]) << (4 * i));
        x.chk  = x.chk ^ cur_enc[i];
      end
      x.chk = exp_chk(x.chk);
      exp_q.push_back(x);
      cur_n = 0;
    end
  endtask

  task automatic model_reset();
    cur_n = 0;
    exp_q.delete();
  endtask

  task automatic cyc();
    logic acc, hs;
    exp_t e;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    if (out_valid && !prev_ov) rise_q.push_back(cycle);
    prev_ov = out_valid;
    if (hs) begin
      cap_word = out_word; cap_key = out_key_word; cap_len = int'(out_len); cap_chk = out_checksum;
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(out_word), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("model_word", 32'(out_word), 32'(e.word));
        check("model_key",  32'(out_key_word), 32'(e.key));
        check("model_len",  32'(out_len), 32'(e.len));
        check("model_chk",  32'(out_checksum), 32'(e.chk));
      end
    end
    if (acc) model_push(in_encrypt_data, in_private_key, in_last);
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic send(input logic [3:0] e, input logic [3:0] k, input logic l);
    int  i;
    bit  got;
    got = 1'b0;
    i   = 0;
    in_valid = 1'b1; in_encrypt_data = e; in_private_key = k; in_last = l;
    while (!got && i < 40) begin
      got = in_ready;
      if (got) acc_cycle = cycle;
      cyc();
      i++;
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int i = 0;
    while (!out_valid && i < bound) begin cyc(); i++; end
    check("wait_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while ((exp_q.size() != 0 || out_valid) && i < bound) begin cyc(); i++; end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_ov", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, k, r0;
    logic [W-1:0] w0, k0;
    logic [3:0] c0;
    logic [2:0] l0;
    logic [W-1:0] ew;

    vecs[0] = '{enc:16'h4321, key:16'hDCBA, n:4, last:1'b0, ew:16'h4321, ek:16'hDCBA, elen:4, echk:4'h4};
    vecs[1] = '{enc:16'h0065, key:16'h0021, n:2, last:1'b1, ew:16'h0065, ek:16'h0021, elen:2, echk:4'h3};
    vecs[2] = '{enc:16'h000F, key:16'h0007, n:1, last:1'b1, ew:16'h000F, ek:16'h0007, elen:1, echk:4'hF};
    vecs[3] = '{enc:16'h0A98, key:16'h0543, n:3, last:1'b1, ew:16'h0A98, ek:16'h0543, elen:3, echk:4'hB};
    vecs[4] = '{enc:16'h7777, key:16'hF0F0, n:4, last:1'b1, ew:16'h7777, ek:16'hF0F0, elen:4, echk:4'h0};

    rst = 1'b1; in_valid = 1'b0; in_encrypt_data = '0; in_private_key = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_word", 32'(out_word), 32'd0);
    check("rst_key", 32'(out_key_word), 32'd0);
    check("rst_len", 32'(out_len), 32'd0);
    check("rst_chk", 32'(out_checksum), 32'd0);
    rst = 1'b0;
    cyc();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors: full word and early-last partial words
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].n; j++)
        send(vecs[v].enc[4*j +: 4], vecs[v].key[4*j +: 4], vecs[v].last && (j == vecs[v].n - 1));
      h0 = hs_cnt;
      for (int i = 0; i < 20 && hs_cnt == h0; i++) cyc();
      check($sformatf("vec%0d_hs", v), 32'(hs_cnt - h0), 32'd1);
      check($sformatf("vec%0d_word", v), 32'(cap_word), 32'(vecs[v].ew));
      check($sformatf("vec%0d_key", v), 32'(cap_key), 32'(vecs[v].ek));
      check($sformatf("vec%0d_len", v), 32'(cap_len), 32'(vecs[v].elen));
      check($sformatf("vec%0d_chk", v), 32'(cap_chk), 32'(exp_chk(vecs[v].echk)));
      wait_idle(10);
    end

    // Backpressure: 9 pairs offered with out_ready low, only 8 fit
    out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (k < 9);
      in_encrypt_data = 4'(k + 1); in_private_key = 4'(15 - k); in_last = 1'b0;
      if (in_valid && in_ready) k++;
      cyc();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(k), 32'd8);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_held_word", 32'(out_word), 32'h4321);
    check("bp_held_key", 32'(out_key_word), 32'hCDEF);
    h0 = hs_cnt;
    out_ready = 1'b1;
    wait_idle(30);
    check("bp_words", 32'(hs_cnt - h0), 32'd2);
    check("bp_last_word", 32'(cap_word), 32'h8765);

    // Streaming: 12 pairs back-to-back, words spaced N+1 cycles
    rise_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      if (i == 0) r0 = acc_cycle;
    end
    wait_idle(30);
    check("stream_rises", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      check("stream_latency", 32'(rise_q[0] - r0), 32'(N + 1));
      check("stream_gap1", 32'(rise_q[1] - rise_q[0]), 32'(N + 1));
      check("stream_gap2", 32'(rise_q[2] - rise_q[1]), 32'(N + 1));
    end

    // Hold stability: outputs frozen while out_ready is low, then a single handshake
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i + 9), 4'(i + 2), 1'b0);
    wait_valid(10);
    w0 = out_word; k0 = out_key_word; l0 = out_len; c0 = out_checksum;
    check("hold_word", 32'(w0), 32'hCBA9);
    send(4'h3, 4'h4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_stable_word", 32'(out_word), 32'(w0));
      check("hold_stable_key", 32'(out_key_word), 32'(k0));
      check("hold_stable_len", 32'(out_len), 32'(l0));
      check("hold_stable_chk", 32'(out_checksum), 32'(c0));
      check("hold_stable_ov", 32'(out_valid), 32'd1);
    end
    h0 = hs_cnt;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("hold_single_hs", 32'(hs_cnt - h0), 32'd1);
    check("hold_ov_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    wait_idle(20);
    check("hold_extra_word", 32'(cap_word), 32'h0003);

    // Reset mid-frame discards the partial word
    out_ready = 1'b1;
    send(4'hE, 4'hE, 1'b0);
    send(4'hD, 4'hD, 1'b0);
    cyc();
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_len", 32'(out_len), 32'd0);
    check("midrst_word", 32'(out_word), 32'd0);
    #2 rst = 1'b0;
    model_reset();
    h0 = hs_cnt;
    send(4'h8, 4'h1, 1'b0);
    send(4'h7, 4'h2, 1'b0);
    send(4'h6, 4'h3, 1'b0);
    send(4'h5, 4'h4, 1'b0);
    wait_idle(20);
    check("midrst_words", 32'(hs_cnt - h0), 32'd1);
    check("midrst_new_word", 32'(cap_word), 32'h5678);
    check("midrst_new_key", 32'(cap_key), 32'h4321);

    // Randomized traffic against the packing model
    for (int i = 0; i < 600; i++) begin
      in_valid        = 1'($urandom_range(0, 1));
      in_encrypt_data = 4'($urandom_range(0, 15));
      in_private_key  = 4'($urandom_range(0, 15));
      in_last         = ($urandom_range(0, 4) == 0);
      out_ready       = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    if (cur_n != 0) begin
      ew = '0;
      send(4'h1, 4'h1, 1'b1);
    end
    wait_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
